// File: rtl/hub75_scan_controller_pkg.sv
// Shared types and constants for the HUB75 scan controller.
package hub75_scan_controller_pkg;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } state_e;

  // Per-column shift phases: top read, bottom read, capture, clock.
  localparam logic [PHASE_W-1:0] PH_TOP = 2'd0;
  localparam logic [PHASE_W-1:0] PH_BOT = 2'd1;
  localparam logic [PHASE_W-1:0] PH_CAP = 2'd2;
  localparam logic [PHASE_W-1:0] PH_CLK = 2'd3;

  // Channel slice offsets inside a pixel word: R high, G middle, B low.
  function automatic int unsigned red_lsb(input int unsigned bpc);
    return 2 * bpc;
  endfunction

  function automatic int unsigned green_lsb(input int unsigned bpc);
    return bpc;
  endfunction

  function automatic int unsigned blue_lsb(input int unsigned bpc);
    return 0;
  endfunction

endpackage

// File: rtl/hub75_addr_gen.sv
// Column/phase/row/plane counters and framebuffer address generation.
module hub75_addr_gen
  import hub75_scan_controller_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned HEIGHT  = 32,
  parameter int unsigned BPC     = 4,
  parameter int unsigned COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int unsigned PLANE_W = (BPC > 1) ? $clog2(BPC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_step,
  input  logic               plane_step,
  output logic [PHASE_W-1:0] phase,
  output logic [COL_W-1:0]   col,
  output logic [ROW_W-1:0]   row,
  output logic [PLANE_W-1:0] plane,
  output logic               col_last_c,
  output logic               plane_last_c,
  output logic               row_last_c,
  output logic [ADDR_W-1:0]  top_addr_c,
  output logic [ADDR_W-1:0]  bot_addr_c
);

  localparam int unsigned HALF_ROWS = HEIGHT / 2;

  // Terminal-count flags and top/bottom half read addresses.
  always_comb begin
    col_last_c   = (col == COL_W'(WIDTH - 1));
    plane_last_c = (plane == PLANE_W'(BPC - 1));
    row_last_c   = (row == ROW_W'(HALF_ROWS - 1));
    top_addr_c   = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);
    bot_addr_c   = top_addr_c + ADDR_W'(HALF_ROWS * WIDTH);
  end

  // Phase/column advance while shifting; plane then row advance after each display.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      col   <= '0;
      row   <= '0;
      plane <= '0;
    end else begin
      if (shift_step) begin
        phase <= phase + PHASE_W'(1);
        if (phase == PH_CLK) begin
          col <= col_last_c ? '0 : col + COL_W'(1);
        end
      end
      if (plane_step) begin
        if (plane_last_c) begin
          plane <= '0;
          row   <= row_last_c ? '0 : row + ROW_W'(1);
        end else begin
          plane <= plane + PLANE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/hub75_scan_controller.sv
// HUB75 LED panel scan controller: reads the framebuffer, shifts bitplanes, BCM display.
module hub75_scan_controller
  import hub75_scan_controller_pkg::*;
#(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned HEIGHT      = 32,
  parameter int unsigned BPP         = 12,
  parameter int unsigned BPC         = 4,
  parameter int unsigned BASE_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] addr_b,
  output logic              re_b,
  output logic              we_b,
  output logic [BPP-1:0]    dat_in_b,
  input  logic [BPP-1:0]    data_out_b,
  output logic              sclk,
  output logic              lat,
  output logic              oe,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              r0,
  output logic              g0,
  output logic              b0,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic              frame_start
);

  localparam int unsigned COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int unsigned DCNT_W  = $clog2((BASE_CYCLES << (BPC - 1)) + 1);
  localparam int unsigned R_LSB   = red_lsb(BPC);
  localparam int unsigned G_LSB   = green_lsb(BPC);
  localparam int unsigned B_LSB   = blue_lsb(BPC);

  state_e              state;
  state_e              state_nxt;
  logic [PHASE_W-1:0]  phase;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [PLANE_W-1:0]  plane;
  logic                col_last_c;
  logic                plane_last_c;
  logic                row_last_c;
  logic [ADDR_W-1:0]   top_addr_c;
  logic [ADDR_W-1:0]   bot_addr_c;
  logic                shift_step;
  logic                plane_step;
  logic [DCNT_W-1:0]   dcnt;
  logic [BPP-1:0]      top_pix;

  logic [ADDR_W-1:0]   addr_d;
  logic                re_d;
  logic                sclk_d;
  logic                lat_d;
  logic                oe_d;
  logic                fs_d;
  logic [ROW_W-1:0]    row_addr_d;
  logic [5:0]          rgb_d;

  // Framebuffer port is read-only.
  assign we_b     = 1'b0;
  assign dat_in_b = '0;

  // Selects the {r,g,b} bits of one pixel word for the given bitplane.
  function automatic logic [2:0] plane_bits(input logic [BPP-1:0] px,
                                            input logic [PLANE_W-1:0] pl);
    logic [BPP-1:0] r_sh;
    logic [BPP-1:0] g_sh;
    logic [BPP-1:0] b_sh;
    r_sh = px >> (R_LSB + 32'(pl));
    g_sh = px >> (G_LSB + 32'(pl));
    b_sh = px >> (B_LSB + 32'(pl));
    return {r_sh[0], g_sh[0], b_sh[0]};
  endfunction

  assign shift_step = (state == ST_SHIFT);
  assign plane_step = (state == ST_DISPLAY) && (dcnt == '0);

  hub75_addr_gen #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .BPC     (BPC),
    .COL_W   (COL_W),
    .PLANE_W (PLANE_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .shift_step   (shift_step),
    .plane_step   (plane_step),
    .phase        (phase),
    .col          (col),
    .row          (row),
    .plane        (plane),
    .col_last_c   (col_last_c),
    .plane_last_c (plane_last_c),
    .row_last_c   (row_last_c),
    .top_addr_c   (top_addr_c),
    .bot_addr_c   (bot_addr_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; en only matters in IDLE and at the frame wrap.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (en) state_nxt = ST_SHIFT;
      ST_SHIFT:   if (phase == PH_CLK && col_last_c) state_nxt = ST_BLANK;
      ST_BLANK:   state_nxt = ST_LATCH;
      ST_LATCH:   state_nxt = ST_DISPLAY;
      ST_DISPLAY: begin
        if (dcnt == '0) begin
          if (plane_last_c && row_last_c && !en) state_nxt = ST_IDLE;
          else                                   state_nxt = ST_SHIFT;
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Display on-time counter and top-half pixel capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt    <= '0;
      top_pix <= '0;
    end else begin
      if (state == ST_LATCH) begin
        dcnt <= DCNT_W'((BASE_CYCLES << plane) - 1);
      end else if (state == ST_DISPLAY && dcnt != '0) begin
        dcnt <= dcnt - DCNT_W'(1);
      end
      if (state == ST_SHIFT && phase == PH_CAP) begin
        top_pix <= data_out_b;
      end
    end
  end

  // Output decode; every panel/memory output is registered below.
  always_comb begin
    addr_d     = addr_b;
    re_d       = 1'b0;
    sclk_d     = 1'b0;
    lat_d      = 1'b0;
    oe_d       = 1'b1;
    fs_d       = 1'b0;
    row_addr_d = {d, c, b, a};
    rgb_d      = {r0, g0, b0, r1, g1, b1};
    case (state)
      ST_SHIFT: begin
        case (phase)
          PH_TOP: begin
            addr_d = top_addr_c;
            re_d   = 1'b1;
            fs_d   = (col == '0) && (row == '0) && (plane == '0);
          end
          PH_BOT: begin
            addr_d = bot_addr_c;
            re_d   = 1'b1;
          end
          PH_CLK: begin
            sclk_d = 1'b1;
            rgb_d  = {plane_bits(top_pix, plane), plane_bits(data_out_b, plane)};
          end
          default: ;
        endcase
      end
      ST_BLANK:   row_addr_d = row;
      ST_LATCH:   lat_d = 1'b1;
      ST_DISPLAY: oe_d = 1'b0;
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_b       <= '0;
      re_b         <= 1'b0;
      sclk         <= 1'b0;
      lat          <= 1'b0;
      oe           <= 1'b1;
      frame_start  <= 1'b0;
      {d, c, b, a} <= '0;
      {r0, g0, b0, r1, g1, b1} <= '0;
    end else begin
      addr_b       <= addr_d;
      re_b         <= re_d;
      sclk         <= sclk_d;
      lat          <= lat_d;
      oe           <= oe_d;
      frame_start  <= fs_d;
      {d, c, b, a} <= row_addr_d;
      {r0, g0, b0, r1, g1, b1} <= rgb_d;
    end
  end

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Directed bench for hub75_scan_controller: vector table plus multi-cycle sequences.
module tb_hub75_scan_controller;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned BPP  = 6;
  localparam int unsigned BPC  = 2;
  localparam int unsigned BASE = 2;
  localparam int unsigned BPP2 = 12;
  localparam int unsigned BPC2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;
  logic en2 = 1'b0;

  logic [13:0] addr_b;
  logic re_b, we_b, sclk, lat, oe, a, b, c, d, r0, g0, b0, r1, g1, b1, frame_start;
  logic [BPP-1:0] dat_in_b;
  logic [BPP-1:0] rd = '0;
  logic [BPP-1:0] mem [0:15];

  logic [13:0] addr_b2;
  logic re_b2, we_b2, sclk2, lat2, oe2, a2, bb2, c2, d2;
  logic r0_2, g0_2, b0_2, r1_2, g1_2, b1_2, fs2;
  logic [BPP2-1:0] dat_in_b2;
  logic [BPP2-1:0] rd2 = '0;
  logic [BPP2-1:0] mem2 [0:15];

  int total = 0;
  int bad   = 0;

  hub75_scan_controller #(.WIDTH(W), .HEIGHT(H), .BPP(BPP), .BPC(BPC), .BASE_CYCLES(BASE)) dut (
    .clk(clk), .rst(rst), .en(en), .addr_b(addr_b), .re_b(re_b), .we_b(we_b),
    .dat_in_b(dat_in_b), .data_out_b(rd), .sclk(sclk), .lat(lat), .oe(oe),
    .a(a), .b(b), .c(c), .d(d), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .frame_start(frame_start)
  );

  hub75_scan_controller #(.WIDTH(W), .HEIGHT(H), .BPP(BPP2), .BPC(BPC2), .BASE_CYCLES(BASE)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .addr_b(addr_b2), .re_b(re_b2), .we_b(we_b2),
    .dat_in_b(dat_in_b2), .data_out_b(rd2), .sclk(sclk2), .lat(lat2), .oe(oe2),
    .a(a2), .b(bb2), .c(c2), .d(d2), .r0(r0_2), .g0(g0_2), .b0(b0_2), .r1(r1_2),
    .g1(g1_2), .b1(b1_2), .frame_start(fs2)
  );

  // Framebuffer models: data valid one clock after re_b.
  always @(posedge clk) if (re_b)  rd  <= mem[addr_b[3:0]];
  always @(posedge clk) if (re_b2) rd2 <= mem2[addr_b2[3:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock, then the always-on invariants for both instances.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("invariant_dut", 32'({lat & ~oe, we_b, |dat_in_b}), 32'd0);
    check("invariant_dut2", 32'({lat2 & ~oe2, we_b2, |dat_in_b2}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (frame_start) ok = 1'b1;
    end
    check("frame_start_seen", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        re;
    logic [13:0] addr;
    logic        sclk;
    logic        lat;
    logic        oe;
    logic        fs;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic re, int unsigned ad,
                              logic sc, logic lt, logic o, logic f);
    vec_t v;
    v.rst = r; v.en = e; v.re = re; v.addr = 14'(ad);
    v.sclk = sc; v.lat = lt; v.oe = o; v.fs = f;
    return v;
  endfunction

  // Reset, then first two and a half columns of row 0 plane 0.
  task automatic seq_table();
    vec_t vecs [12];
    logic [18:0] got, want;
    vecs[0]  = mk(1, 0, 0,  0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 1, 0,  0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 1, 1,  0, 0, 0, 1, 1);
    vecs[3]  = mk(0, 1, 1,  8, 0, 0, 1, 0);
    vecs[4]  = mk(0, 1, 0,  8, 0, 0, 1, 0);
    vecs[5]  = mk(0, 1, 0,  8, 1, 0, 1, 0);
    vecs[6]  = mk(0, 1, 1,  1, 0, 0, 1, 0);
    vecs[7]  = mk(0, 1, 1,  9, 0, 0, 1, 0);
    vecs[8]  = mk(0, 1, 0,  9, 0, 0, 1, 0);
    vecs[9]  = mk(0, 1, 0,  9, 1, 0, 1, 0);
    vecs[10] = mk(0, 1, 1,  2, 0, 0, 1, 0);
    vecs[11] = mk(0, 1, 1, 10, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      tick();
      got  = {re_b, addr_b, sclk, lat, oe, frame_start};
      want = {vecs[i].re, vecs[i].addr, vecs[i].sclk, vecs[i].lat, vecs[i].oe, vecs[i].fs};
      check($sformatf("vec%0d_{re,addr,sclk,lat,oe,fs}", i), 32'(got), 32'(want));
    end
  endtask

  // One full frame with en held: timing, row addresses and pixel bits.
  task automatic seq_frame();
    bit ok;
    int frame_len = -1, lats = 0, rises = 0, re_cnt = 0, run = 0;
    int runs [$];
    logic [3:0] alat [$];
    logic sclk_prev = 1'b0;
    int exp_runs [4];
    logic [3:0] exp_alat [5];
    exp_runs = '{2, 4, 2, 4};
    exp_alat = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
    do_reset();
    en = 1'b1;
    wait_fs(ok);
    for (int cyc = 0; cyc < 300 && lats < 5; cyc++) begin
      if (cyc > 0) tick();
      if (cyc > 0 && frame_start && frame_len < 0) frame_len = cyc;
      if (frame_len < 0) begin
        if (re_b) re_cnt++;
        if (sclk && !sclk_prev) begin
          int k, seg, cl, rw, pl;
          logic [BPP-1:0] t, bt;
          k = rises; rises++;
          seg = k / 4; cl = k % 4; rw = seg / BPC; pl = seg % BPC;
          t  = mem[rw * W + cl];
          bt = mem[rw * W + cl + (H / 2) * W];
          check($sformatf("pixel_rise%0d", k), 32'({r0, g0, b0, r1, g1, b1}),
                32'({t[4 + pl], t[2 + pl], t[pl], bt[4 + pl], bt[2 + pl], bt[pl]}));
        end
      end
      if (!oe) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
      if (lat) begin lats++; alat.push_back({d, c, b, a}); end
      sclk_prev = sclk;
    end
    check("frame_len", 32'(frame_len), 32'd84);
    check("sclk_rises", 32'(rises), 32'd16);
    check("re_b_cycles", 32'(re_cnt), 32'd32);
    check("display_run_count", 32'(runs.size()), 32'd4);
    for (int i = 0; i < runs.size() && i < 4; i++)
      check($sformatf("display_run%0d", i), 32'(runs[i]), 32'(exp_runs[i]));
    check("lat_count", 32'(alat.size()), 32'd5);
    for (int i = 0; i < alat.size() && i < 5; i++)
      check($sformatf("row_at_lat%0d", i), 32'(alat[i]), 32'(exp_alat[i]));
  endtask

  // en dropped mid-frame: frame completes, then idle.
  task automatic seq_en_drop();
    bit ok;
    int re_cnt = 0, lats = 0, fs_cnt = 0, late = 0, oe_low = 0;
    do_reset();
    en = 1'b1;
    wait_fs(ok);
    for (int cyc = 0; cyc <= 150; cyc++) begin
      if (cyc == 10) en = 1'b0;
      if (cyc > 0) begin
        tick();
        if (frame_start) fs_cnt++;
      end
      if (re_b) re_cnt++;
      if (lat) lats++;
      if (!oe) oe_low++;
      if (cyc >= 84 && (!oe || re_b)) late++;
    end
    check("endrop_re_b_cycles", 32'(re_cnt), 32'd32);
    check("endrop_lat_count", 32'(lats), 32'd4);
    check("endrop_oe_low_cycles", 32'(oe_low), 32'd12);
    check("endrop_extra_frame_start", 32'(fs_cnt), 32'd0);
    check("endrop_activity_after_frame", 32'(late), 32'd0);
  endtask

  // Reset during a row-1 display period.
  task automatic seq_rst_display();
    bit found = 1'b0;
    int act = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (!oe && a) found = 1'b1;
    end
    check("display_row1_reached", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_in_display_outputs",
          32'({addr_b, re_b, sclk, lat, oe, frame_start, d, c, b, a, r0, g0, b0, r1, g1, b1}),
          32'({14'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0}));
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!oe || re_b || frame_start || lat || sclk) act++;
    end
    check("idle_after_rst", 32'(act), 32'd0);
  endtask

  // 12-bit words, 4 bits per channel: first column pixel bits.
  task automatic seq_pixel_bpc4();
    bit found = 1'b0;
    do_reset();
    en2 = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (sclk2) found = 1'b1;
    end
    check("dut2_sclk_seen", 32'(found), 32'd1);
    check("dut2_col0_rgb", 32'({r0_2, g0_2, b0_2, r1_2, g1_2, b1_2}), 32'(6'b100001));
    en2 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 6'((i * 13 + 5) % 64);
      mem2[i] = '0;
    end
    mem2[0] = 12'hF00;
    mem2[8] = 12'h00F;
    seq_table();
    seq_frame();
    seq_en_drop();
    seq_rst_display();
    seq_pixel_bpc4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
